// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes and debounces the coin-slot and arm sensors,
// keeps a saturating credit balance and issues one-cycle unlock, push and reject pulses.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FARE            = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_raw,
  input  logic [1:0] coin_value,
  input  logic       push_raw,
  output logic       coin,
  output logic       push,
  output logic [3:0] credit,
  output logic       reject
);

  localparam logic [7:0] CNT_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] FARE_U     = 5'(FARE);
  localparam logic [4:0] CREDIT_MAX = 5'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_CREDIT, ST_VEND, ST_GAP} state_t;

  // Bit 0 carries the coin slot, bit 1 the turnstile arm.
  logic [1:0] raw_s1_q;
  logic [1:0] raw_s2_q;
  logic [1:0] val_s1_q;
  logic [1:0] val_s2_q;
  logic [1:0] rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_s1_q <= '0;
      raw_s2_q <= '0;
      val_s1_q <= '0;
      val_s2_q <= '0;
    end else begin
      raw_s1_q <= {push_raw, coin_raw};
      raw_s2_q <= raw_s1_q;
      val_s1_q <= coin_value;
      val_s2_q <= val_s1_q;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
    logic [7:0] cnt_q;
    logic       level_q;
    logic       level_prev_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q        <= '0;
        level_q      <= 1'b0;
        level_prev_q <= 1'b0;
      end else begin
        level_prev_q <= level_q;
        if (raw_s2_q[gi] == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_q   <= '0;
          level_q <= raw_s2_q[gi];
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end

    assign rise[gi] = level_q & ~level_prev_q;
  end

  logic       coin_evt;
  logic       push_evt;
  logic [4:0] units_d;
  logic [4:0] sum_raw_d;
  logic [4:0] sum_d;
  logic       reject_d;
  logic       accept_d;
  logic       fare_met_d;

  state_t     state_q;
  logic [3:0] credit_q;
  logic       coin_q;
  logic       push_q;
  logic       reject_q;

  assign coin_evt = rise[0];
  assign push_evt = rise[1];

  always_comb begin
    units_d = 5'd0;
    case (val_s2_q)
      2'b01:   units_d = 5'd1;
      2'b10:   units_d = 5'd2;
      2'b11:   units_d = 5'd5;
      default: units_d = 5'd0;
    endcase
    sum_raw_d  = {1'b0, credit_q} + units_d;
    // Invalid denominations and overflowing coins are refused outright, never wrapped.
    reject_d   = coin_evt && ((units_d == 5'd0) || (sum_raw_d > CREDIT_MAX));
    accept_d   = coin_evt && !reject_d;
    sum_d      = accept_d ? sum_raw_d : {1'b0, credit_q};
    fare_met_d = (sum_d >= FARE_U);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      coin_q   <= 1'b0;
      push_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      push_q   <= push_evt;
      reject_q <= reject_d;
      coin_q   <= 1'b0;
      case (state_q)
        ST_VEND: begin
          credit_q <= sum_d[3:0];
          state_q  <= ST_GAP;
        end
        // GAP re-evaluates the balance, so a vend can never directly follow a vend.
        ST_GAP: begin
          if (fare_met_d) begin
            credit_q <= 4'(sum_d - FARE_U);
            state_q  <= ST_VEND;
            coin_q   <= 1'b1;
          end else begin
            credit_q <= sum_d[3:0];
            state_q  <= (sum_d == 5'd0) ? ST_IDLE : ST_CREDIT;
          end
        end
        default: begin
          if (accept_d && fare_met_d) begin
            credit_q <= 4'(sum_d - FARE_U);
            state_q  <= ST_VEND;
            coin_q   <= 1'b1;
          end else begin
            credit_q <= sum_d[3:0];
            state_q  <= (sum_d == 5'd0) ? ST_IDLE : ST_CREDIT;
          end
        end
      endcase
    end
  end

  assign coin   = coin_q;
  assign push   = push_q;
  assign credit = credit_q;
  assign reject = reject_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: three instances (fares 3, 1, 15) share one stimulus stream
// and are compared every cycle against a sample-history reference model.
module tb_coin_acceptor;

  localparam int D    = 4;
  localparam int NI   = 3;
  localparam int MAXC = 4096;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       coin_raw   = 1'b0;
  logic [1:0] coin_value = 2'b00;
  logic       push_raw   = 1'b0;

  logic       coin_w   [NI];
  logic       push_w   [NI];
  logic       reject_w [NI];
  logic [3:0] credit_w [NI];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    coin_acceptor #(
      .DEBOUNCE_CYCLES(D),
      .FARE(gi == 0 ? 3 : (gi == 1 ? 1 : 15))
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .coin_raw   (coin_raw),
      .coin_value (coin_value),
      .push_raw   (push_raw),
      .coin       (coin_w[gi]),
      .push       (push_w[gi]),
      .credit     (credit_w[gi]),
      .reject     (reject_w[gi])
    );
  end

  // ---------------- reference model ----------------
  // Raw samples are logged per clock edge since reset release. A debounced level
  // flips when the D samples that have reached the filter all disagree with it;
  // an event is acted on one edge after a rising flip.
  bit         c_hist [MAXC];
  bit         p_hist [MAXC];
  logic [1:0] v_hist [MAXC];
  int         m_cyc;
  bit         m_clvl, m_plvl, m_crose, m_prose;
  int         m_credit [NI];
  bit         m_vended [NI];
  bit         e_coin [NI];
  bit         e_push [NI];
  bit         e_rej  [NI];
  int         m_units;
  int         m_sum;
  bit         m_rej;

  function automatic int fare_of(input int i);
    return (i == 0) ? 3 : ((i == 1) ? 1 : 15);
  endfunction

  function automatic int units_of(input logic [1:0] v);
    case (v)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  function automatic bit c_at(input int k);
    return (k < 0 || k >= MAXC) ? 1'b0 : c_hist[k];
  endfunction

  function automatic bit p_at(input int k);
    return (k < 0 || k >= MAXC) ? 1'b0 : p_hist[k];
  endfunction

  function automatic logic [1:0] v_at(input int k);
    return (k < 0 || k >= MAXC) ? 2'b00 : v_hist[k];
  endfunction

  function automatic bit window_differs(input bit sel_push, input int n, input bit lvl);
    for (int k = n - D - 1; k <= n - 2; k++) begin
      if ((sel_push ? p_at(k) : c_at(k)) == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cyc = 0; m_clvl = 0; m_plvl = 0; m_crose = 0; m_prose = 0;
      for (int i = 0; i < NI; i++) begin
        m_credit[i] = 0; m_vended[i] = 0;
        e_coin[i] = 0; e_push[i] = 0; e_rej[i] = 0;
      end
    end else begin
      m_units = units_of(v_at(m_cyc - 2));
      for (int i = 0; i < NI; i++) begin
        m_rej = m_crose && (m_units == 0 || m_credit[i] + m_units > 15);
        m_sum = m_credit[i] + ((m_crose && !m_rej) ? m_units : 0);
        // A vend is possible on any edge except the one right after a vend.
        if (!m_vended[i] && m_sum >= fare_of(i)) begin
          m_sum = m_sum - fare_of(i);
          m_vended[i] = 1'b1;
        end else begin
          m_vended[i] = 1'b0;
        end
        m_credit[i] = m_sum;
        e_coin[i]   = m_vended[i];
        e_rej[i]    = m_rej;
        e_push[i]   = m_prose;
      end
      if (window_differs(1'b0, m_cyc, m_clvl)) begin
        m_clvl = !m_clvl; m_crose = m_clvl;
      end else m_crose = 1'b0;
      if (window_differs(1'b1, m_cyc, m_plvl)) begin
        m_plvl = !m_plvl; m_prose = m_plvl;
      end else m_prose = 1'b0;
      if (m_cyc < MAXC) begin
        c_hist[m_cyc] = coin_raw;
        p_hist[m_cyc] = push_raw;
        v_hist[m_cyc] = coin_value;
      end
      m_cyc++;
    end
  end

  function automatic logic [20:0] obs_vec();
    logic [20:0] v;
    v = '0;
    for (int i = 0; i < NI; i++) v[i*7 +: 7] = {coin_w[i], push_w[i], reject_w[i], credit_w[i]};
    return v;
  endfunction

  function automatic logic [20:0] exp_vec();
    logic [20:0] v;
    v = '0;
    for (int i = 0; i < NI; i++) v[i*7 +: 7] = {e_coin[i], e_push[i], e_rej[i], 4'(m_credit[i])};
    return v;
  endfunction

  // One line per output transaction.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset && (coin_w[i] || push_w[i] || reject_w[i]))
        $display("[TB] t=%0t inst=%0d coin=%0b push=%0b reject=%0b credit=%0d",
                 $time, i, coin_w[i], push_w[i], reject_w[i], credit_w[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    coin_raw = 1'b0; push_raw = 1'b0; coin_value = 2'b00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    coin_raw = 1'b1; push_raw = 1'b1; coin_value = 2'b11;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if (obs_vec() !== 21'd0) begin
        fails++; $display("FAIL reset_hold dut=%h required=0", obs_vec());
      end
    end
    coin_raw = 1'b0; push_raw = 1'b0; coin_value = 2'b00;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      tests++;
      if (obs_vec() !== 21'd0) begin
        fails++; $display("FAIL reset_idle c=%0d dut=%h required=0", c, obs_vec());
      end
    end
  endtask

  task automatic test_basic_coins();
    int pulses;
    pulses = 0;
    do_reset();
    coin_value = 2'b01;
    for (int c = 0; c < 90; c++) begin
      coin_raw = ((c % 30) < 15);
      @(posedge clk); #1;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL model_basic c=%0d dut=%h model=%h", c, obs_vec(), exp_vec());
      end
      if (coin_w[0]) pulses++;
      if (c == 5) begin
        tests++;
        if (credit_w[0] !== 4'd0) begin
          fails++; $display("FAIL basic_early c=5 credit=%0d required=0", credit_w[0]);
        end
      end
      if (c == 6) begin
        tests++;
        if (credit_w[0] !== 4'd1 || coin_w[0] !== 1'b0) begin
          fails++; $display("FAIL basic_first credit=%0d coin=%0b required 1/0", credit_w[0], coin_w[0]);
        end
      end
      if (c == 36) begin
        tests++;
        if (credit_w[0] !== 4'd2) begin
          fails++; $display("FAIL basic_second credit=%0d required=2", credit_w[0]);
        end
      end
      if (c == 66) begin
        tests++;
        if (coin_w[0] !== 1'b1 || credit_w[0] !== 4'd0) begin
          fails++; $display("FAIL basic_vend coin=%0b credit=%0d required 1/0", coin_w[0], credit_w[0]);
        end
      end
    end
    tests++;
    if (pulses !== 1) begin
      fails++; $display("FAIL basic_pulses got=%0d required=1", pulses);
    end
  endtask

  task automatic test_big_coin();
    int pulses;
    pulses = 0;
    do_reset();
    coin_value = 2'b11;
    for (int c = 0; c < 30; c++) begin
      coin_raw = (c < 15);
      @(posedge clk); #1;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL model_big c=%0d dut=%h model=%h", c, obs_vec(), exp_vec());
      end
      if (coin_w[0]) pulses++;
      if (c == 6 || c == 7) begin
        tests++;
        if (coin_w[0] !== (c == 6) || credit_w[0] !== 4'd2) begin
          fails++; $display("FAIL big_vend c=%0d coin=%0b credit=%0d required %0b/2", c, coin_w[0], credit_w[0], c == 6);
        end
      end
    end
    tests++;
    if (pulses !== 1 || credit_w[0] !== 4'd2) begin
      fails++; $display("FAIL big_final pulses=%0d credit=%0d required 1/2", pulses, credit_w[0]);
    end
  endtask

  task automatic test_bounce();
    int events;
    events = 0;
    do_reset();
    coin_value = 2'b01;
    for (int c = 0; c < 80; c++) begin
      coin_raw = (c < 10) || (c >= 20 && c < 40 && (((c - 20) / 2) % 2 == 0));
      push_raw = (c >= 45 && c < 48);
      @(posedge clk); #1;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL model_bounce c=%0d dut=%h model=%h", c, obs_vec(), exp_vec());
      end
      if (c >= 20) begin
        for (int i = 0; i < NI; i++) if (coin_w[i] || push_w[i] || reject_w[i]) events++;
        tests++;
        if (credit_w[0] !== 4'd1) begin
          fails++; $display("FAIL bounce_credit c=%0d credit=%0d required=1", c, credit_w[0]);
        end
      end
    end
    tests++;
    if (events !== 0) begin
      fails++; $display("FAIL bounce_events got=%0d required=0", events);
    end
  endtask

  task automatic test_reject();
    logic [1:0] vals [7];
    vals = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
    do_reset();
    for (int c = 0; c < 140; c++) begin
      coin_value = vals[c / 20];
      coin_raw   = ((c % 20) < 10);
      @(posedge clk); #1;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL model_reject c=%0d dut=%h model=%h", c, obs_vec(), exp_vec());
      end
      if (c == 86 || c == 87) begin
        tests++;
        if (reject_w[2] !== (c == 86) || credit_w[2] !== 4'd14) begin
          fails++; $display("FAIL reject_sat c=%0d reject=%0b credit=%0d required %0b/14", c, reject_w[2], credit_w[2], c == 86);
        end
      end
      if (c == 106) begin
        tests++;
        if (reject_w[2] !== 1'b1 || reject_w[0] !== 1'b1 || credit_w[2] !== 4'd14) begin
          fails++; $display("FAIL reject_invalid rej2=%0b rej0=%0b credit=%0d required 1/1/14", reject_w[2], reject_w[0], credit_w[2]);
        end
      end
      if (c == 126) begin
        tests++;
        if (coin_w[2] !== 1'b1 || credit_w[2] !== 4'd0) begin
          fails++; $display("FAIL reject_fill coin=%0b credit=%0d required 1/0", coin_w[2], credit_w[2]);
        end
      end
    end
  endtask

  task automatic test_fare1_push();
    int pulses;
    pulses = 0;
    do_reset();
    coin_value = 2'b10;
    for (int c = 0; c < 30; c++) begin
      coin_raw = (c < 12);
      push_raw = (c < 12);
      @(posedge clk); #1;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL model_fare1 c=%0d dut=%h model=%h", c, obs_vec(), exp_vec());
      end
      if (coin_w[1]) pulses++;
      if (c >= 6 && c <= 9) begin
        tests++;
        if (coin_w[1] !== (c == 6 || c == 8) || push_w[1] !== (c == 6)) begin
          fails++; $display("FAIL fare1_pulse c=%0d coin=%0b push=%0b", c, coin_w[1], push_w[1]);
        end
      end
    end
    tests++;
    if (pulses !== 2 || credit_w[1] !== 4'd0) begin
      fails++; $display("FAIL fare1_final pulses=%0d credit=%0d required 2/0", pulses, credit_w[1]);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    int events;
    pulses = 0; events = 0;
    do_reset();
    coin_value = 2'b11;
    coin_raw = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    tests++;
    if (obs_vec() !== 21'd0) begin
      fails++; $display("FAIL abort_debounce dut=%h required=0", obs_vec());
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL model_abort c=%0d dut=%h model=%h", c, obs_vec(), exp_vec());
      end
      if (coin_w[0]) pulses++;
    end
    tests++;
    if (pulses !== 1 || coin_w[0] !== 1'b1) begin
      fails++; $display("FAIL abort_latency pulses=%0d coin=%0b required 1/1", pulses, coin_w[0]);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (obs_vec() !== 21'd0) begin
      fails++; $display("FAIL abort_vend dut=%h required=0", obs_vec());
    end
    coin_raw = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) if (coin_w[i] || push_w[i] || reject_w[i] || credit_w[i] != 0) events++;
    end
    tests++;
    if (events !== 0) begin
      fails++; $display("FAIL abort_quiet activity=%0d required=0", events);
    end
  endtask

  task automatic test_back_to_back();
    int pulses [NI];
    bit prev [NI];
    for (int i = 0; i < NI; i++) begin pulses[i] = 0; prev[i] = 0; end
    do_reset();
    coin_value = 2'b11;
    for (int c = 0; c < 240; c++) begin
      coin_raw = (c < 200) && ((c % 10) < 5);
      push_raw = (c < 200) && ((c % 9) < 5);
      @(posedge clk); #1;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL model_b2b c=%0d dut=%h model=%h", c, obs_vec(), exp_vec());
      end
      for (int i = 0; i < NI; i++) begin
        if (coin_w[i]) begin
          pulses[i]++;
          tests++;
          if (prev[i]) begin
            fails++; $display("FAIL b2b_gap inst=%0d c=%0d consecutive coin pulses", i, c);
          end
        end
        prev[i] = coin_w[i];
      end
    end
    // 20 five-unit coins: every unit ends up either vended or still on credit.
    for (int i = 0; i < NI; i++) begin
      tests++;
      if (pulses[i] * fare_of(i) + int'(credit_w[i]) !== 100) begin
        fails++; $display("FAIL b2b_conserve inst=%0d pulses=%0d credit=%0d required total 100", i, pulses[i], credit_w[i]);
      end
    end
  endtask

  task automatic test_random();
    int c_hold, p_hold, low_run;
    bit c_lvl, p_lvl;
    bit prev [NI];
    c_hold = 0; p_hold = 0; low_run = 0; c_lvl = 0; p_lvl = 0;
    for (int i = 0; i < NI; i++) prev[i] = 0;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (c_hold == 0) begin
        c_lvl = !c_lvl;
        c_hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 14));
      end
      c_hold--;
      if (p_hold == 0) begin
        p_lvl = !p_lvl;
        p_hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 20));
      end
      p_hold--;
      if (!c_lvl) begin
        low_run++;
        if (low_run > 6) coin_value = 2'($urandom_range(0, 3));
      end else begin
        low_run = 0;
      end
      coin_raw = c_lvl;
      push_raw = p_lvl;
      @(posedge clk); #1;
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL model_random c=%0d dut=%h model=%h", c, obs_vec(), exp_vec());
      end
      for (int i = 0; i < NI; i++) begin
        if (coin_w[i]) begin
          tests++;
          if (prev[i]) begin
            fails++; $display("FAIL random_gap inst=%0d c=%0d consecutive coin pulses", i, c);
          end
        end
        prev[i] = coin_w[i];
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_coins();
    test_big_coin();
    test_bounce();
    test_reject();
    test_fare1_push();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
